array_port_arbiter: RTL and testbench
=====================================

Name: array_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency array between two streams: a read-address stream returning read data, and a write stream (address + data).
- Sits between a stream compute function and an `array` instance; replaces direct wiring of the compute block to the array port.
- Arbitrates round-robin under contention, tracks in-flight reads, and buffers read data so a stalled consumer never loses a word.

Parameters:
- ADDR_N, 4, array address width
- DATA_N, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ra  in  ADDR_N  read address
- ra_valid  in  1  read address valid
- ra_ready  out  1  read address accepted this cycle
- wa  in  ADDR_N  write address
- wa_valid  in  1  write address valid
- wa_ready  out  1  write address accepted this cycle
- w  in  DATA_N  write data
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted; always equal to wa_ready
- rd  out  DATA_N  read data
- rd_valid  out  1  read data valid
- rd_ready  in  1  consumer ready
- arr_addr  out  ADDR_N  array address
- arr_we  out  1  array write enable
- arr_wdata  out  DATA_N  array write data
- arr_rdata  in  DATA_N  array read data, valid the cycle after the address is presented

Behaviour:
- Reset (asynchronous, active-high):
  - rd_valid=0, arr_we=0, arr_addr=0, arr_wdata=0.
  - Buffer empty, in-flight flag clear, last_grant=READ, so a write wins the first conflict.
- Request conditions:
  - Write request: wa_valid && w_valid. A write never consumes one without the other.
  - Read request: ra_valid && credit, where credit means (inflight + buf_count − pop) < 2 and pop = rd_valid && rd_ready.
- Grant (combinational, one grant per cycle):
  - Only one request present: that request wins.
  - Both present: the side opposite last_grant wins. last_grant updates on every grant.
- Write grant:
  - wa_ready=w_ready=1, arr_we=1, arr_addr=wa, arr_wdata=w.
  - The array commits at this clock edge.
- Read grant:
  - ra_ready=1, arr_we=0, arr_addr=ra.
  - inflight is set for the next cycle; at that cycle arr_rdata is pushed into the buffer.
- Idle: arr_we=0; arr_addr holds the last value (registered copy), so it does not toggle.
- Read data buffer:
  - 2-entry FIFO; rd and rd_valid come from the head.
  - Push and pop in the same cycle are allowed.
  - The credit rule guarantees no overflow.
- Throughput:
  - One array access per cycle.
  - Sustained reads run 1 per cycle when rd_ready=1.
  - Read latency: ra accepted at edge t gives rd_valid=1 after edge t+1 (2 cycles) when the buffer is empty.
- Ordering: a read granted the cycle after a write to the same address returns the new data. Accesses take effect in grant order.
- Fairness: with both requesters continuously valid and credit available, grants strictly alternate W,R,W,R…
- Backpressure: with rd_ready=0, at most 2 reads are accepted, then ra_ready=0. Writes continue to be granted every cycle.
- Stability: rd and rd_valid hold while rd_valid && !rd_ready.
- Reset mid-operation: the in-flight read and buffered data are discarded; no pending array write is retried.

Test Plan:
- Writes only: wa=0..15, w=addr+1, all valid every cycle -> wa_ready=w_ready=1 each cycle, arr_we=1, 16 cycles total; array holds mem[i]=i+1.
- Reads after fill: ra=0..15 back-to-back, rd_ready=1 -> rd sequence 1..16, first rd_valid 2 cycles after first accept, then one per cycle.
- Contention: wa=3,w=99 and ra=3 both valid from reset -> write granted first, read granted next cycle, rd=99; for continuous requests the grant pattern is W,R,W,R.
- Backpressure: rd_ready=0, ra=0,1,2 offered -> only 0 and 1 accepted, ra_ready=0 afterwards. Raise rd_ready -> rd=1 then 2, then ra=2 accepted, rd=3.
- Mismatched write halves: wa_valid=1, w_valid=0 for 3 cycles -> no grant, arr_we=0. Raise w_valid -> single write committed.
- Async reset while rd_valid=1 with 2 entries buffered -> rd_valid drops immediately without a clock edge; after release the first read returns correct data with no stale words.

Source files
------------

// File: rtl/array_port_arbiter_if.sv
// rtl/array_port_arbiter_if.sv - read/write stream and array port bundle for the array port arbiter
interface array_port_arbiter_if #(
  parameter int ADDR_N = 4,
  parameter int DATA_N = 32
);
  logic [ADDR_N-1:0] ra;
  logic              ra_valid;
  logic              ra_ready;
  logic [ADDR_N-1:0] wa;
  logic              wa_valid;
  logic              wa_ready;
  logic [DATA_N-1:0] w;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_N-1:0] rd;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [DATA_N-1:0] arr_wdata;
  logic [DATA_N-1:0] arr_rdata;

  // Arbiter side: consumes request streams and the array read port, drives the array.
  modport slave (
    input  ra, ra_valid, wa, wa_valid, w, w_valid, rd_ready, arr_rdata,
    output ra_ready, wa_ready, w_ready, rd, rd_valid, arr_addr, arr_we, arr_wdata
  );

  // Compute/array side: produces requests, consumes read data and array commands.
  modport master (
    output ra, ra_valid, wa, wa_valid, w, w_valid, rd_ready, arr_rdata,
    input  ra_ready, wa_ready, w_ready, rd, rd_valid, arr_addr, arr_we, arr_wdata
  );
endinterface

// File: rtl/array_port_arbiter.sv
// rtl/array_port_arbiter.sv - round-robin sharing of a single-port array between a read and a write stream
module array_port_arbiter #(
  parameter int ADDR_N = 4,
  parameter int DATA_N = 32
) (
  input  logic                clk,
  input  logic                rst,
  array_port_arbiter_if.slave bus
);
  logic              last_w;      // 1: last grant went to the write stream
  logic              inflight;    // a read was issued last cycle; arr_rdata is valid now
  logic [DATA_N-1:0] buf_q [2];
  logic              head;
  logic [1:0]        count;
  logic [ADDR_N-1:0] addr_q;
  logic [DATA_N-1:0] wdata_q;

  logic       pop;
  logic       push;
  logic [1:0] occupancy;
  logic       credit;
  logic       wreq;
  logic       rreq;
  logic       grant_w;
  logic       grant_r;
  logic       tail;

  // Request qualification and one-hot grant; nothing is granted while reset is held.
  always_comb begin
    pop       = (count != 2'd0) && bus.rd_ready;
    push      = inflight;
    tail      = head ^ count[0];
    // Reads already issued or buffered, minus the one leaving this cycle.
    occupancy = {1'b0, inflight} + count - {1'b0, pop};
    credit    = (occupancy < 2'd2);
    wreq      = !rst && bus.wa_valid && bus.w_valid;
    rreq      = !rst && bus.ra_valid && credit;
    grant_w   = wreq && (!rreq || !last_w);
    grant_r   = rreq && !grant_w;
  end

  assign bus.wa_ready  = grant_w;
  assign bus.w_ready   = grant_w;
  assign bus.ra_ready  = grant_r;
  assign bus.arr_we    = grant_w;
  assign bus.arr_addr  = grant_w ? bus.wa : (grant_r ? bus.ra : addr_q);
  assign bus.arr_wdata = grant_w ? bus.w : wdata_q;
  assign bus.rd        = buf_q[head];
  assign bus.rd_valid  = (count != 2'd0);

  // Arbitration history, held array command, in-flight tracking and buffer pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_w   <= 1'b0;
      inflight <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (grant_w) begin
        last_w  <= 1'b1;
        addr_q  <= bus.wa;
        wdata_q <= bus.w;
      end else if (grant_r) begin
        last_w <= 1'b0;
        addr_q <= bus.ra;
      end
      inflight <= grant_r;
      head     <= head ^ pop;
      count    <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Read data storage; contents are don't-care while count says the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[tail] <= bus.arr_rdata;
    end
  end
endmodule

// File: tb/tb_array_port_arbiter.sv
// tb/tb_array_port_arbiter.sv - randomized and directed self-checking bench for array_port_arbiter
module tb_array_port_arbiter;
  localparam int AN = 4;
  localparam int DN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  array_port_arbiter_if #(.ADDR_N(AN), .DATA_N(DN)) bus ();
  array_port_arbiter #(.ADDR_N(AN), .DATA_N(DN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Array instance with one cycle read latency; not reset.
  logic [DN-1:0] amem [16];
  always @(posedge clk) begin
    if (bus.arr_we) amem[bus.arr_addr] <= bus.arr_wdata;
    bus.arr_rdata <= amem[bus.arr_addr];
  end

  // Reference model: shadow memory updated in grant order, queue of reads accepted but not yet consumed.
  typedef struct {
    logic [DN-1:0] data;
    int            age;
  } rd_t;
  logic [DN-1:0] smem [16];
  rd_t           q[$];
  bit            last_w;
  logic [AN-1:0] last_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_w    = 1'b0;
    last_addr = '0;
  endtask

  task automatic step(input bit rav, input logic [AN-1:0] ra, input bit wav, input logic [AN-1:0] wa,
                      input bit wv, input logic [DN-1:0] w, input bit rdr, output bit acc_r, output bit acc_w);
    bit exp_rv, pop, credit, wreq, rreq, gw, gr;
    @(negedge clk);
    bus.ra_valid = rav; bus.ra = ra;
    bus.wa_valid = wav; bus.wa = wa;
    bus.w_valid  = wv;  bus.w  = w;
    bus.rd_ready = rdr;
    #1;
    exp_rv = (q.size() > 0) && (q[0].age >= 2);
    pop    = exp_rv && rdr;
    credit = (q.size() - int'(pop)) < 2;
    wreq   = wav && wv;
    rreq   = rav && credit;
    gw     = wreq && (!rreq || !last_w);
    gr     = rreq && !gw;
    check("wa_ready", 64'(bus.wa_ready), 64'(gw));
    check("w_ready", 64'(bus.w_ready), 64'(gw));
    check("ra_ready", 64'(bus.ra_ready), 64'(gr));
    check("arr_we", 64'(bus.arr_we), 64'(gw));
    check("rd_valid", 64'(bus.rd_valid), 64'(exp_rv));
    if (exp_rv) check("rd", 64'(bus.rd), 64'(q[0].data));
    check("arr_addr", 64'(bus.arr_addr), 64'(gw ? wa : (gr ? ra : last_addr)));
    if (gw) check("arr_wdata", 64'(bus.arr_wdata), 64'(w));
    if (pop) void'(q.pop_front());
    if (gw) begin
      smem[wa]  = w;
      last_w    = 1'b1;
      last_addr = wa;
    end
    if (gr) begin
      q.push_back('{data: smem[ra], age: 0});
      last_w    = 1'b0;
      last_addr = ra;
    end
    foreach (q[i]) q[i].age++;
    acc_r = gr;
    acc_w = gw;
  endtask

  task automatic idle(input int n, input bit rdr);
    bit ar, aw;
    repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, '0, rdr, ar, aw);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, "_arr_we"}, 64'(bus.arr_we), 64'd0);
    check({tag, "_arr_addr"}, 64'(bus.arr_addr), 64'd0);
    check({tag, "_arr_wdata"}, 64'(bus.arr_wdata), 64'd0);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ar, aw;
    int idx;
    for (int i = 0; i < 16; i++) begin
      amem[i] = '0;
      smem[i] = '0;
    end
    bus.ra_valid = 1'b0; bus.ra = '0;
    bus.wa_valid = 1'b0; bus.wa = '0;
    bus.w_valid  = 1'b0; bus.w  = '0;
    bus.rd_ready = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Writes only: mem[i] = i+1, one grant per cycle.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 4'(i), 1'b1, 32'(i + 1), 1'b1, ar, aw);
      check("fill_accept", 64'(aw), 64'd1);
    end

    // Back-to-back reads after fill.
    idx = 0;
    for (int c = 0; c < 40 && idx < 16; c++) begin
      step(1'b1, 4'(idx), 1'b0, '0, 1'b0, '0, 1'b1, ar, aw);
      if (ar) idx++;
    end
    check("reads_accepted", 64'(idx), 64'd16);
    idle(3, 1'b1);

    // Contention from reset: write wins first, then strict alternation.
    sync_reset();
    for (int c = 0; c < 8; c++) step(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 32'd99, 1'b1, ar, aw);
    idle(3, 1'b1);

    // Backpressure: only two reads accepted while the consumer stalls.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 4'(idx), 1'b0, '0, 1'b0, '0, 1'b0, ar, aw);
      if (ar) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    for (int c = 0; c < 10 && idx < 3; c++) begin
      step(1'b1, 4'(idx), 1'b0, '0, 1'b0, '0, 1'b1, ar, aw);
      if (ar) idx++;
    end
    check("bp_resume", 64'(idx), 64'd3);
    idle(4, 1'b1);

    // Mismatched write halves: no grant until both valid.
    repeat (3) step(1'b0, '0, 1'b1, 4'd5, 1'b0, 32'd55, 1'b1, ar, aw);
    step(1'b0, '0, 1'b1, 4'd5, 1'b1, 32'd55, 1'b1, ar, aw);
    idle(1, 1'b1);
    step(1'b1, 4'd5, 1'b0, '0, 1'b0, '0, 1'b1, ar, aw);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom(),
           $urandom_range(0, 2) != 0, ar, aw);
    end
    idle(4, 1'b1);

    // Async reset with two words buffered and the consumer stalled.
    idx = 0;
    for (int c = 0; c < 6 && idx < 2; c++) begin
      step(1'b1, 4'(idx + 7), 1'b0, '0, 1'b0, '0, 1'b0, ar, aw);
      if (ar) idx++;
    end
    idle(3, 1'b0);
    check("pre_reset_rd_valid", 64'(bus.rd_valid), 64'd1);
    check("pre_reset_depth", 64'(q.size()), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i * 3), 1'b0, '0, 1'b0, '0, 1'b1, ar, aw);
    idle(4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
